// File: rtl/cordic_pkg.sv
// Shared definitions for the 16-bit CORDIC rotation pipeline:
// widths, angle constants, the x seed, the per-stage atan table and the sample bundle.
package cordic_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_STAGES = 16;

  // Binary angles: full circle = 2^16, so pi is the MSB alone.
  localparam logic [DATA_W-1:0] ANG_PI      = 16'h8000;
  localparam logic [DATA_W-1:0] ANG_HALF_PI = 16'h4000;

  // 0.607253 in Q2.14 pre-cancels the CORDIC gain of the stage chain.
  localparam logic [DATA_W-1:0] X_INIT_DEFAULT = 16'h26DD;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } cordic_sample_t;

  // atan(2^-i) in binary-angle LSBs, rounded; stage i subtracts/adds this from z.
  function automatic logic [DATA_W-1:0] atan_lut(input int unsigned stage);
    logic [DATA_W-1:0] val;
    case (stage)
      0:       val = 16'd8192;
      1:       val = 16'd4836;
      2:       val = 16'd2555;
      3:       val = 16'd1297;
      4:       val = 16'd651;
      5:       val = 16'd326;
      6:       val = 16'd163;
      7:       val = 16'd81;
      8:       val = 16'd41;
      9:       val = 16'd20;
      10:      val = 16'd10;
      11:      val = 16'd5;
      12:      val = 16'd3;
      13:      val = 16'd1;
      14:      val = 16'd1;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

  // The pi pre-rotation is needed when the angle lies in the second or third quadrant.
  function automatic logic needs_pi_fold(input logic [DATA_W-1:0] angle);
    return angle[DATA_W-1] ^ angle[DATA_W-2];
  endfunction

endpackage

// File: rtl/cordic_flag_delay.sv
// Fixed-length {valid, flag} shift register with asynchronous clear.
// Used to carry per-sample sideband bits alongside a pipeline of known depth.
module cordic_flag_delay #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic flag_in,
  output logic valid_out,
  output logic flag_out
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] flag_sr;

  // The truncating cast keeps the shift legal for DEPTH == 1 as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      flag_sr  <= '0;
    end else begin
      valid_sr <= DEPTH'({valid_sr, valid_in});
      flag_sr  <= DEPTH'({flag_sr, flag_in});
    end
  end

  assign valid_out = valid_sr[DEPTH-1];
  assign flag_out  = flag_sr[DEPTH-1] & valid_sr[DEPTH-1];

endmodule

// File: rtl/cordic_prerotate.sv
// CORDIC input stage: folds the angle into +-pi/2 by a pi rotation, registers the
// x/y/z seeds, delays the negate flag to the end of the stage chain and counts samples in flight.
module cordic_prerotate
  import cordic_pkg::*;
#(
  parameter  int                PIPE_DEPTH = 16,
  parameter  logic [DATA_W-1:0] X_INIT     = X_INIT_DEFAULT,
  localparam int                CNT_W      = $clog2(PIPE_DEPTH + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] angle_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              neg_valid,
  output logic              neg_out,
  output logic [CNT_W-1:0]  inflight,
  output logic              idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_DEPTH + 1);

  logic              fold;
  logic [DATA_W-1:0] z_fold;
  cordic_sample_t    seed;
  logic              seed_neg;

  // Flipping the MSB adds pi modulo 2^16, moving quadrants 01/10 into 11/00.
  assign fold   = needs_pi_fold(angle_in);
  assign z_fold = fold ? (angle_in ^ ANG_PI) : angle_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed     <= '0;
      seed_neg <= 1'b0;
    end else begin
      seed.valid <= valid_in;
      seed_neg   <= valid_in & fold;
      if (valid_in) begin
        seed.x <= X_INIT;
        seed.y <= '0;
        seed.z <= z_fold;
      end
    end
  end

  assign valid_out = seed.valid;
  assign x_out     = seed.x;
  assign y_out     = seed.y;
  assign z_out     = seed.z;

  cordic_flag_delay #(
    .DEPTH(PIPE_DEPTH)
  ) u_neg_delay (
    .clk      (clk),
    .reset    (reset),
    .valid_in (seed.valid),
    .flag_in  (seed_neg),
    .valid_out(neg_valid),
    .flag_out (neg_out)
  );

  // A sample counts from its accept edge until the edge after its neg_valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({valid_in, neg_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0);

  a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
    inflight <= CNT_MAX);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(valid_in && !neg_valid && inflight == CNT_MAX));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(neg_valid && !valid_in && inflight == '0));

endmodule

// File: tb/tb_cordic_prerotate.sv
// Scoreboard bench for cordic_prerotate: directed angles with hand-computed folds,
// a reference CORDIC chain for end-to-end cos/sin, and timing of both output strobes.
module tb_cordic_prerotate;

  localparam int  PIPE_DEPTH = 16;
  localparam int  CNT_W      = 5;
  localparam real PI         = 3.14159265358979323846;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [15:0]      angle_in;
  logic             valid_out;
  logic [15:0]      x_out;
  logic [15:0]      y_out;
  logic [15:0]      z_out;
  logic             neg_valid;
  logic             neg_out;
  logic [CNT_W-1:0] inflight;
  logic             idle;

  cordic_prerotate #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .angle_in (angle_in),
    .valid_out(valid_out),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .neg_valid(neg_valid),
    .neg_out  (neg_out),
    .inflight (inflight),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] angle;
    logic [15:0] z;
    logic        neg;
    int          stamp;
    real         cx;
    real         cy;
  } sb_entry_t;

  sb_entry_t seed_q[$];
  sb_entry_t neg_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Hand-computed folds: angle, reduced z, negate flag.
  logic [15:0] vec_ang [10] = '{16'h2000, 16'h6000, 16'h8000, 16'h4000, 16'hC000,
                                16'hA000, 16'h7FFF, 16'h1234, 16'h5555, 16'hE000};
  logic [15:0] vec_z   [10] = '{16'h2000, 16'hE000, 16'h0000, 16'hC000, 16'hC000,
                                16'h2000, 16'hFFFF, 16'h1234, 16'hD555, 16'hE000};
  logic        vec_neg [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference occupancy: a sample is in flight for PIPE_DEPTH+1 edges after acceptance.
  logic [PIPE_DEPTH:0] vin_hist;
  int                  exp_inflight;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vin_hist     <= '0;
      exp_inflight <= 0;
    end else begin
      exp_inflight <= exp_inflight + int'(valid_in) - int'(vin_hist[PIPE_DEPTH]);
      vin_hist     <= {vin_hist[PIPE_DEPTH-1:0], valid_in};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkNear(input string name, input real act, input real exp, input real tol);
    real diff;
    vectors++;
    diff = act - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > tol) begin
      miscompares++;
      $display("[TB] FAIL %s: got %f, expected %f +/- %f (cycle %0d)", name, act, exp, tol, cyc);
    end
  endtask

  task automatic flagUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: strobe with empty scoreboard, expected none (cycle %0d)", name, cyc);
  endtask

  // Real-valued 16-stage rotation-mode CORDIC from the given seeds.
  function automatic void cordicModel(input logic [15:0] x0, input logic [15:0] y0,
                                      input logic [15:0] z0, output real xr, output real yr);
    real x, y, z, scale, xn;
    x = $itor($signed(x0));
    y = $itor($signed(y0));
    z = $itor($signed(z0)) * PI / 32768.0;
    scale = 1.0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (z >= 0.0) begin
        xn = x - y * scale;
        y  = y + x * scale;
        z  = z - $atan(scale);
      end else begin
        xn = x + y * scale;
        y  = y - x * scale;
        z  = z + $atan(scale);
      end
      x = xn;
      scale = scale / 2.0;
    end
    xr = x;
    yr = y;
  endfunction

  always @(negedge clk) begin
    sb_entry_t e;
    real theta, fx, fy;
    if (!reset) begin
      checkOutput("inflight", 32'(inflight), 32'(exp_inflight));
      checkOutput("idle", 32'(idle), 32'(exp_inflight == 0));
      if (valid_out) begin
        if (seed_q.size() == 0) begin
          flagUnexpected("valid_out");
        end else begin
          e = seed_q.pop_front();
          checkOutput("valid_out latency", 32'(cyc), 32'(e.stamp));
          checkOutput("x_out", 32'(x_out), 32'h26DD);
          checkOutput("y_out", 32'(y_out), 32'h0000);
          checkOutput("z_out", 32'(z_out), 32'(e.z));
          cordicModel(16'h26DD, 16'h0000, e.z, e.cx, e.cy);
          neg_q.push_back(e);
        end
      end
      if (neg_valid) begin
        if (neg_q.size() == 0) begin
          flagUnexpected("neg_valid");
        end else begin
          e = neg_q.pop_front();
          checkOutput("neg_valid latency", 32'(cyc), 32'(e.stamp + PIPE_DEPTH));
          checkOutput("neg_out", 32'(neg_out), 32'(e.neg));
          theta = $itor($signed(e.angle)) * PI / 32768.0;
          fx = neg_out ? -e.cx : e.cx;
          fy = neg_out ? -e.cy : e.cy;
          checkNear("final cos", fx, 16384.0 * $cos(theta), 4.0);
          checkNear("final sin", fy, 16384.0 * $sin(theta), 4.0);
        end
      end else begin
        checkOutput("neg_out without strobe", 32'(neg_out), 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] ang,
                               input logic [15:0] ez, input logic en);
    @(negedge clk);
    valid_in = v;
    angle_in = ang;
    if (v) seed_q.push_back('{angle: ang, z: ez, neg: en, stamp: cyc + 1, cx: 0.0, cy: 0.0});
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic applyVector(input int idx);
    applyStimulus(1'b1, vec_ang[idx], vec_z[idx], vec_neg[idx]);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " valid_out"}, 32'(valid_out), 32'h0);
    checkOutput({tag, " x_out"}, 32'(x_out), 32'h0);
    checkOutput({tag, " y_out"}, 32'(y_out), 32'h0);
    checkOutput({tag, " z_out"}, 32'(z_out), 32'h0);
    checkOutput({tag, " neg_valid"}, 32'(neg_valid), 32'h0);
    checkOutput({tag, " neg_out"}, 32'(neg_out), 32'h0);
    checkOutput({tag, " inflight"}, 32'(inflight), 32'h0);
    checkOutput({tag, " idle"}, 32'(idle), 32'h1);
  endtask

  initial begin
    int max_inflight;
    int neg_pulses;
    int waited;
    logic [6:0] gap_pattern;

    reset    = 1'b1;
    valid_in = 1'b0;
    angle_in = 16'h0000;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    $display("[TB] single sample");
    applyVector(0);
    applyIdle(22);

    $display("[TB] quadrant sweep");
    for (int i = 1; i <= 5; i++) applyVector(i);
    applyIdle(22);

    $display("[TB] continuous stream of 40");
    max_inflight = 0;
    for (int i = 0; i < 40; i++) begin
      applyVector(i % 10);
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
    end
    for (int i = 0; i < 22; i++) begin
      applyIdle(1);
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
    end
    checkOutput("stream peak inflight", 32'(max_inflight), 32'd17);
    checkOutput("idle after stream", 32'(idle), 32'h1);

    $display("[TB] gapped pattern");
    gap_pattern = 7'b1011001;
    for (int i = 6; i >= 0; i--) begin
      if (gap_pattern[i]) applyVector((12 - i) % 10);
      else applyIdle(1);
    end
    applyIdle(22);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 9; i++) applyVector((i + 3) % 10);
    @(posedge clk);
    #2;
    checkOutput("inflight before reset", 32'(inflight), 32'd9);
    valid_in = 1'b0;
    reset    = 1'b1;
    seed_q.delete();
    neg_q.delete();
    #1;
    checkResetState("async reset");
    @(negedge clk);
    reset = 1'b0;
    neg_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (neg_valid) neg_pulses++;
    end
    checkOutput("neg_valid pulses after reset", 32'(neg_pulses), 32'h0);

    $display("[TB] steady accept and retire");
    for (int i = 0; i < 30; i++) applyVector((i * 3) % 10);
    applyIdle(1);

    waited = 0;
    while ((seed_q.size() != 0 || neg_q.size() != 0) && waited < 100) begin
      applyIdle(1);
      waited++;
    end
    checkOutput("scoreboard drained", 32'(seed_q.size() + neg_q.size()), 32'h0);
    applyIdle(2);
    checkOutput("idle at end", 32'(idle), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
